// File: rtl/if_id_reg.sv
// IF/ID pipeline register for the 5-stage MIPS pipeline.
// Captures PC, PC+4 and the fetched instruction each cycle. The hazard unit
// can stall it (IFIDWrite=0), and a taken branch or jump can flush it to a
// bubble (IF_Flush=1). Saturating debug counters track stalls, flushes and
// real instructions loaded.
//
// Ports:
//   clk        clock, all updates on posedge
//   reset      synchronous active-high reset
//   PC_in      PC of the instruction being fetched
//   PC4_in     PC_in + 4 from the IF adder (registered as given)
//   Instr_in   instruction memory read data
//   IFIDWrite  1 = load, 0 = hold (stall)
//   IF_Flush   1 = insert bubble (wins over a stall)
//   PC_out     registered PC to ID
//   PC4_out    registered PC+4 to ID
//   Instr_out  registered instruction to ID
//   Valid_out  1 = real instruction, 0 = bubble
//   stall_cnt  saturating count of hold cycles
//   flush_cnt  saturating count of flush cycles
//   instr_cnt  saturating count of loaded instructions
module if_id_reg #(
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PC_in,
  input  logic [31:0]      PC4_in,
  input  logic [31:0]      Instr_in,
  input  logic             IFIDWrite,
  input  logic             IF_Flush,
  output logic [31:0]      PC_out,
  output logic [31:0]      PC4_out,
  output logic [31:0]      Instr_out,
  output logic             Valid_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Event decode in priority order: reset > flush > hold > load.
  logic do_flush_c;
  logic do_hold_c;
  logic do_load_c;

  always_comb begin
    do_flush_c = 1'b0;
    do_hold_c  = 1'b0;
    do_load_c  = 1'b0;
    if (!reset) begin
      if (IF_Flush) begin
        do_flush_c = 1'b1;
      end else if (!IFIDWrite) begin
        do_hold_c = 1'b1;
      end else begin
        do_load_c = 1'b1;
      end
    end
  end

  // Pipeline payload; a hold simply leaves the flops untouched so an X on
  // the inputs during a stall never reaches the outputs.
  always_ff @(posedge clk) begin
    if (reset || do_flush_c) begin
      PC_out    <= DATA_W'(0);
      PC4_out   <= DATA_W'(0);
      Instr_out <= NOP_INSTR;
      Valid_out <= 1'b0;
    end else if (do_load_c) begin
      PC_out    <= PC_in;
      PC4_out   <= PC4_in;
      Instr_out <= Instr_in;
      Valid_out <= 1'b1;
    end
  end

  // Saturating event counters; the decode above is one-hot so at most one
  // counter moves per edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= CNT_W'(0);
      flush_cnt <= CNT_W'(0);
      instr_cnt <= CNT_W'(0);
    end else begin
      if (do_hold_c && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (do_flush_c && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (do_load_c && (instr_cnt != CNT_MAX)) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: a behavioural model checked every
// negedge, plus literal expectations from the directed scenarios.
module tb_if_id_reg;

  localparam int unsigned CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      PC_in, PC4_in, Instr_in;
  logic             IFIDWrite, IF_Flush;
  logic [31:0]      PC_out, PC4_out, Instr_out;
  logic             Valid_out;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, instr_cnt;

  int checks = 0;
  int errors = 0;

  if_id_reg #(.CNT_W(CNT_W), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .PC_in(PC_in), .PC4_in(PC4_in), .Instr_in(Instr_in),
    .IFIDWrite(IFIDWrite), .IF_Flush(IF_Flush),
    .PC_out(PC_out), .PC4_out(PC4_out), .Instr_out(Instr_out),
    .Valid_out(Valid_out),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the ID stage should see after each edge.
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int          m_stall, m_flush, m_instr_n;
  bit          m_ok = 1'b0;

  function automatic int sat_inc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_pc <= 0; m_pc4 <= 0; m_instr <= 0; m_valid <= 0;
      m_stall <= 0; m_flush <= 0; m_instr_n <= 0;
      m_ok <= 1'b1;
    end else if (IF_Flush) begin
      m_pc <= 0; m_pc4 <= 0; m_instr <= 0; m_valid <= 0;
      m_flush <= sat_inc(m_flush);
    end else if (!IFIDWrite) begin
      m_stall <= sat_inc(m_stall);
    end else begin
      m_pc <= PC_in; m_pc4 <= PC4_in; m_instr <= Instr_in; m_valid <= 1;
      m_instr_n <= sat_inc(m_instr_n);
    end
  end

  // Compare process: DUT against model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_ok) begin
      check("m_pc",    PC_out,            m_pc);
      check("m_pc4",   PC4_out,           m_pc4);
      check("m_instr", Instr_out,         m_instr);
      check("m_valid", 32'(Valid_out),    32'(m_valid));
      check("m_stall", 32'(stall_cnt),    32'(m_stall));
      check("m_flush", 32'(flush_cnt),    32'(m_flush));
      check("m_icnt",  32'(instr_cnt),    32'(m_instr_n));
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the edge.
  task automatic cyc(input logic r, input logic w, input logic f,
                     input logic [31:0] pc, input logic [31:0] pc4,
                     input logic [31:0] ins);
    reset = r; IFIDWrite = w; IF_Flush = f;
    PC_in = pc; PC4_in = pc4; Instr_in = ins;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_data(input string tag, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic [31:0] ins,
                          input logic v);
    check({tag, "_pc"},    PC_out,         pc);
    check({tag, "_pc4"},   PC4_out,        pc4);
    check({tag, "_instr"}, Instr_out,      ins);
    check({tag, "_valid"}, 32'(Valid_out), 32'(v));
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f, input int i);
    check({tag, "_stall"}, 32'(stall_cnt), 32'(s));
    check({tag, "_flush"}, 32'(flush_cnt), 32'(f));
    check({tag, "_icnt"},  32'(instr_cnt), 32'(i));
  endtask

  initial begin
    reset = 1'b1; IFIDWrite = 1'b1; IF_Flush = 1'b0;
    PC_in = 32'h0; PC4_in = 32'h0; Instr_in = 32'h0;
    #2;

    // Reset then load
    cyc(1, 1, 0, 32'h0, 32'h4, 32'h2008_0005);
    cyc(1, 1, 0, 32'h0, 32'h4, 32'h2008_0005);
    chk_data("rst", 0, 0, 0, 0);
    chk_cnt("rst", 0, 0, 0);
    cyc(0, 1, 0, 32'h0, 32'h4, 32'h2008_0005);
    chk_data("load0", 32'h0, 32'h4, 32'h2008_0005, 1);
    chk_cnt("load0", 0, 0, 1);

    // Stall for 3 cycles while inputs move on
    cyc(0, 1, 0, 32'h8, 32'hC, 32'h8C09_0000);
    chk_data("load8", 32'h8, 32'hC, 32'h8C09_0000, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 32'hC, 32'h10, 32'h0109_5020);
      chk_data("hold", 32'h8, 32'hC, 32'h8C09_0000, 1);
    end
    chk_cnt("hold3", 3, 0, 2);
    cyc(0, 1, 0, 32'hC, 32'h10, 32'h0109_5020);
    chk_data("loadC", 32'hC, 32'h10, 32'h0109_5020, 1);
    chk_cnt("loadC", 3, 0, 3);

    // Flush kills the incoming branch-shadow instruction
    cyc(0, 1, 1, 32'h10, 32'h14, 32'h1128_0003);
    chk_data("flush", 0, 0, 0, 0);
    chk_cnt("flush", 3, 1, 3);

    // Flush and stall on the same edge: flush wins
    cyc(0, 1, 0, 32'h20, 32'h24, 32'hAABB_CCDD);
    chk_data("load20", 32'h20, 32'h24, 32'hAABB_CCDD, 1);
    cyc(0, 0, 1, 32'h24, 32'h28, 32'h1234_5678);
    chk_data("fl_st", 0, 0, 0, 0);
    chk_cnt("fl_st", 3, 2, 4);

    // Reset mid-stall, with X on the instruction bus while holding
    cyc(0, 1, 0, 32'h30, 32'h34, 32'h0000_0020);
    cyc(0, 0, 0, 32'h34, 32'h38, 32'hxxxx_xxxx);
    cyc(0, 0, 0, 32'h34, 32'h38, 32'hxxxx_xxxx);
    chk_data("holdx", 32'h30, 32'h34, 32'h0000_0020, 1);
    chk_cnt("pre_rst", 5, 2, 5);
    cyc(1, 0, 0, 32'h34, 32'h38, 32'hxxxx_xxxx);
    chk_data("rst_mid", 0, 0, 0, 0);
    chk_cnt("rst_mid", 0, 0, 0);

    // Stall counter saturates at 15
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 32'h40, 32'h44, 32'hDEAD_BEEF);
    chk_cnt("sat_st", 15, 0, 0);
    chk_data("sat_st", 0, 0, 0, 0);

    // Instruction and flush counters saturate too; PC4 taken as given
    for (int k = 0; k < 20; k++)
      cyc(0, 1, 0, 32'(k * 4), 32'(k * 4 + 100), 32'(32'h1000 + k));
    chk_data("lastld", 32'd76, 32'd176, 32'h1013, 1);
    chk_cnt("sat_ld", 15, 0, 15);
    for (int k = 0; k < 17; k++) cyc(0, k[0], 1, 32'h50, 32'h54, 32'hCAFE_0000);
    chk_cnt("sat_fl", 15, 15, 15);

    // Mixed tail exercised against the model only
    for (int k = 0; k < 12; k++)
      cyc(1'(k == 7), 1'(k % 3 != 1), 1'(k % 5 == 4),
          32'(k * 8), 32'(k * 8 + 4), 32'(32'h2000 + k));

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
